// File: rtl/uart_rx_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM encoding,
// default frame geometry and the three-sample majority function.
package uart_rx_pkg;

  localparam int DIVISION_DEF  = 16;
  localparam int DATA_BITS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_vote.sv
// Captures the synchronized line at the three mid-bit ticks and presents the
// majority of those samples for the current bit.
module uart_rx_vote
  import uart_rx_pkg::*;
#(
  parameter int DIVISION = DIVISION_DEF,
  parameter int TICK_W   = $clog2(DIVISION)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sampling,
  input  logic              active,
  input  logic [TICK_W-1:0] tick_cnt,
  input  logic              rx_s,
  output logic              vote
);

  localparam int HALF = DIVISION / 2;

  logic [2:0] at_tick;
  logic [2:0] samp_reg;

  for (genvar gi = 0; gi < 3; gi++) begin : g_tick_match
    assign at_tick[gi] = (tick_cnt == TICK_W'(HALF - 1 + gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_reg <= 3'b111;
    end else if (sampling && active) begin
      for (int i = 0; i < 3; i++) begin
        if (at_tick[i]) samp_reg[i] <= rx_s;
      end
    end
  end

  // On the last sample tick the third sample is taken live, so a decision
  // made on that very pulse (stop bit) already sees the full vote.
  assign vote = at_tick[2] ? maj3(samp_reg[0], samp_reg[1], rx_s)
                           : maj3(samp_reg[0], samp_reg[1], samp_reg[2]);

endmodule

// File: rtl/uart_rx_ctrl.sv
// Oversampling UART receiver: 2-flop synchronizer, start/data/stop FSM
// advanced only by the sampling strobe, majority-voted bit recovery.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DIVISION  = DIVISION_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sampling,
  input  logic                 rx,
  input  logic                 en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TICK_W = $clog2(DIVISION);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(DIVISION - 1);
  localparam logic [TICK_W-1:0] STOP_TICK = TICK_W'(DIVISION / 2 + 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic                 rx_meta_reg;
  logic                 rx_s;
  rx_state_e            state_reg;
  logic [TICK_W-1:0]    tick_reg;
  logic [BIT_W-1:0]     bit_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 vote;
  logic                 bit_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_s        <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s        <= rx_meta_reg;
    end
  end

  uart_rx_vote #(
    .DIVISION (DIVISION),
    .TICK_W   (TICK_W)
  ) u_vote (
    .clk      (clk),
    .rst_n    (rst_n),
    .sampling (sampling),
    .active   (state_reg != IDLE),
    .tick_cnt (tick_reg),
    .rx_s     (rx_s),
    .vote     (vote)
  );

  assign bit_end = (tick_reg == LAST_TICK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      tick_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (sampling) begin
        tick_reg <= bit_end ? '0 : tick_reg + TICK_W'(1);
        case (state_reg)
          IDLE: begin
            tick_reg <= '0;
            if (en && !rx_s) begin
              // this pulse is tick 0 of the start bit
              state_reg <= START;
              tick_reg  <= TICK_W'(1);
              busy      <= 1'b1;
            end
          end
          START: begin
            if (bit_end) begin
              if (vote) begin
                state_reg <= IDLE;
                busy      <= 1'b0;
              end else begin
                state_reg <= DATA;
                bit_reg   <= '0;
              end
            end
          end
          DATA: begin
            if (bit_end) begin
              shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
              bit_reg   <= bit_reg + BIT_W'(1);
              if (bit_reg == LAST_BIT) begin
                state_reg <= STOP;
                bit_reg   <= '0;
              end
            end
          end
          STOP: begin
            // decide at the last mid-bit sample so the next start edge is
            // seen on the very next pulse
            if (tick_reg == STOP_TICK) begin
              state_reg <= IDLE;
              tick_reg  <= '0;
              busy      <= 1'b0;
              if (vote) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end
          end
          default: begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
